// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
//  Module      : alu_cmd_sequencer
//  Description : Command FIFO in front of a combinational ALU with a
//                registered result slot. Both sides use valid/ready.
//                Optional macro ALU_FWD_EN: per-entry forwarding of the
//                previous result into operand A.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_sequencer #(
    parameter int WIDTH  = 16,
    parameter int MODE_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WIDTH-1:0]  cmd_a,
    input  logic [WIDTH-1:0]  cmd_b,
    input  logic              cmd_cin,
    input  logic [MODE_W-1:0] cmd_mode,
    input  logic              cmd_fwd,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic              alu_cin,
    output logic [MODE_W-1:0] alu_mode,
    input  logic [WIDTH-1:0]  alu_y,
    input  logic              alu_cout,
    input  logic              alu_overflow,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WIDTH-1:0]  res_y,
    output logic              res_cout,
    output logic              res_overflow,
    output logic              busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] c_full = CW'(DEPTH);

    // EXEC: head present, slot free. STALL: head present, slot occupied
    // (a pop still happens in STALL when the consumer takes the slot).
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_pop;
    logic              w_push;
    logic              w_empty;
    logic              w_res_valid_nxt;
    logic [CW-1:0]     w_count_nxt;

    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_res_valid;
    logic [WIDTH-1:0]  r_res_y;
    logic              r_res_cout;
    logic              r_res_overflow;

    logic [WIDTH-1:0]  r_mem_a    [DEPTH];
    logic [WIDTH-1:0]  r_mem_b    [DEPTH];
    logic              r_mem_cin  [DEPTH];
    logic [MODE_W-1:0] r_mem_mode [DEPTH];

`ifdef ALU_FWD_EN
    logic              r_mem_fwd  [DEPTH];
    logic [WIDTH-1:0]  r_last_y;
`else
    logic              w_unused_fwd;
    assign w_unused_fwd = cmd_fwd;
`endif

    // Ready depends on registered occupancy only, never on res_ready.
    assign cmd_ready    = (r_count != c_full);
    assign w_push       = cmd_valid & cmd_ready;
    assign w_empty      = (r_count == '0);
    assign res_valid    = r_res_valid;
    assign res_y        = r_res_y;
    assign res_cout     = r_res_cout;
    assign res_overflow = r_res_overflow;
    assign busy         = ~w_empty | r_res_valid;

    // Next-state and pop decision; state tracks next count / slot occupancy.
    always_comb begin
        w_state_nxt     = S_IDLE;
        w_pop           = 1'b0;
        w_count_nxt     = r_count;
        w_res_valid_nxt = r_res_valid & ~res_ready;
        case (r_state)
            S_EXEC:  w_pop = 1'b1;
            S_STALL: w_pop = res_ready;
            default: w_pop = 1'b0;
        endcase
        if (w_pop) begin
            w_res_valid_nxt = 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
        if (w_count_nxt == '0) begin
            w_state_nxt = S_IDLE;
        end else if (w_res_valid_nxt) begin
            w_state_nxt = S_STALL;
        end else begin
            w_state_nxt = S_EXEC;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Head of FIFO drives the ALU; zeros when nothing is queued.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_cin  = 1'b0;
        alu_mode = '0;
        if (!w_empty) begin
            alu_a    = r_mem_a[r_rd_ptr];
            alu_b    = r_mem_b[r_rd_ptr];
            alu_cin  = r_mem_cin[r_rd_ptr];
            alu_mode = r_mem_mode[r_rd_ptr];
`ifdef ALU_FWD_EN
            if (r_mem_fwd[r_rd_ptr]) begin
                alu_a = r_last_y;
            end
`endif
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]    <= cmd_a;
            r_mem_b[r_wr_ptr]    <= cmd_b;
            r_mem_cin[r_wr_ptr]  <= cmd_cin;
            r_mem_mode[r_wr_ptr] <= cmd_mode;
`ifdef ALU_FWD_EN
            r_mem_fwd[r_wr_ptr]  <= cmd_fwd;
`endif
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
        end
    end

    // Result slot: capture on pop, otherwise hold until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_valid    <= 1'b0;
            r_res_y        <= '0;
            r_res_cout     <= 1'b0;
            r_res_overflow <= 1'b0;
        end else begin
            r_res_valid <= w_res_valid_nxt;
            if (w_pop) begin
                r_res_y        <= alu_y;
                r_res_cout     <= alu_cout;
                r_res_overflow <= alu_overflow;
            end
        end
    end

`ifdef ALU_FWD_EN
    // Most recent ALU result, used as operand A by forwarding entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_y <= '0;
        end else if (w_pop) begin
            r_last_y <= alu_y;
        end
    end
`endif

endmodule

`default_nettype wire
